vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 157 +++++++++++++++
 tb/tb_vram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: display reads have absolute priority, CPU accesses are queued behind them
module vram_arbiter #(
  parameter int CPU_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        module_en,
  input  logic        disp_req,
  input  logic [18:0] disp_addr,
  output logic [11:0] disp_data,
  output logic        disp_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_ack,
  output logic [11:0] cpu_rdata,
  output logic        cpu_timeout,
  input  logic        err_clr,
  output logic [18:0] mem_addr,
  output logic        mem_we,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    RDWAIT,
    ACK
  } state_t;

  // Timeout threshold widened by one bit so a saturated counter still compares correctly.
  localparam logic [16:0] TIMEOUT_LIM = 17'(CPU_TIMEOUT);

  state_t      state;
  logic        hold_we;
  logic [18:0] hold_addr;
  logic [11:0] hold_wdata;
  logic [15:0] cpu_wait_cnt;

  logic        cpu_issue;
  logic        cpu_stall;
  logic        timeout_hit;

  // The CPU only gets the port in PEND on a cycle the display leaves free.
  assign cpu_issue   = (state == PEND) && !disp_req && module_en;
  // A stall is a PEND cycle lost to the display.
  assign cpu_stall   = (state == PEND) && disp_req && module_en;
  // The stall being counted this cycle brings the wait count up to the threshold.
  assign timeout_hit = cpu_stall && (({1'b0, cpu_wait_cnt} + 17'd1) >= TIMEOUT_LIM);

  // Memory port mux: display address unless the held CPU access is issued now.
  assign mem_addr  = cpu_issue ? hold_addr : disp_addr;
  assign mem_we    = cpu_issue & hold_we;
  assign mem_wdata = hold_wdata;

  // Display data comes straight from the memory; disp_valid marks which cycles carry it.
  assign disp_data = mem_rdata;

  // CPU transaction FSM with registered busy/ack outputs and request holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      cpu_busy   <= 1'b0;
      cpu_ack    <= 1'b0;
    end else if (!module_en) begin
      state    <= IDLE;
      cpu_busy <= 1'b0;
      cpu_ack  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ack <= 1'b0;
          if (cpu_req) begin
            hold_we    <= cpu_we;
            hold_addr  <= cpu_addr;
            hold_wdata <= cpu_wdata;
            cpu_busy   <= 1'b1;
            state      <= PEND;
          end
        end
        PEND: begin
          if (!disp_req) begin
            if (hold_we) begin
              state   <= ACK;
              cpu_ack <= 1'b1;
            end else begin
              state <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          state   <= ACK;
          cpu_ack <= 1'b1;
        end
        ACK: begin
          state    <= IDLE;
          cpu_ack  <= 1'b0;
          cpu_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cpu_ack  <= 1'b0;
          cpu_busy <= 1'b0;
        end
      endcase
    end
  end

  // CPU read data is captured in the cycle after the read address was presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata <= '0;
    end else if (module_en && (state == RDWAIT)) begin
      cpu_rdata <= mem_rdata;
    end
  end

  // Display read valid follows the request by exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= disp_req & module_en;
    end
  end

  // Saturating count of display-stall cycles for the current CPU request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_wait_cnt <= '0;
    end else if (!module_en) begin
      cpu_wait_cnt <= '0;
    end else if ((state == IDLE) && cpu_req) begin
      cpu_wait_cnt <= '0;
    end else if (cpu_stall && (cpu_wait_cnt != 16'hFFFF)) begin
      cpu_wait_cnt <= cpu_wait_cnt + 16'd1;
    end
  end

  // Sticky timeout flag; a new hit outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_timeout <= 1'b0;
    end else if (timeout_hit) begin
      cpu_timeout <= 1'b1;
    end else if (err_clr) begin
      cpu_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter against a transaction-level model
module tb_vram_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        module_en;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic [11:0] disp_data;
  logic        disp_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [11:0] cpu_wdata;
  logic        cpu_busy;
  logic        cpu_ack;
  logic [11:0] cpu_rdata;
  logic        cpu_timeout;
  logic        err_clr;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  vram_arbiter #(.CPU_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .module_en(module_en),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_timeout(cpu_timeout),
    .err_clr(err_clr), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // VRAM behavioural model: synchronous read, one cycle latency; unwritten words hold a known pattern.
  logic [11:0] vram    [0:524287];
  bit          vram_wr [0:524287];
  logic [11:0] shadow    [0:524287];
  bit          shadow_wr [0:524287];

  function automatic logic [11:0] init_val(input logic [18:0] a);
    logic [31:0] v;
    v = {13'd0, a} * 32'd37 + 32'd5;
    return v[11:0];
  endfunction

  function automatic logic [11:0] vram_rd(input logic [18:0] a);
    if (vram_wr[a]) return vram[a];
    return init_val(a);
  endfunction

  function automatic logic [11:0] sh_rd(input logic [18:0] a);
    if (shadow_wr[a]) return shadow[a];
    return init_val(a);
  endfunction

  always @(posedge clk) begin
    mem_rdata <= vram_rd(mem_addr);
    if (mem_we === 1'b1) begin
      vram[mem_addr]    <= mem_wdata;
      vram_wr[mem_addr] <= 1'b1;
    end
  end

  int total = 0;
  int bad = 0;

  // Reference model state (transaction level)
  int          cyc = 0;
  bit          m_busy, m_issued, m_we, m_to, m_prev_disp;
  logic [18:0] m_addr;
  logic [11:0] m_wdata, m_rdata, m_pend_rdata, m_prev_exp;
  int          m_ack_cyc, m_stalls;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_we = 0; m_to = 0; m_prev_disp = 0;
    m_rdata = '0; m_stalls = 0; m_ack_cyc = -1;
  endtask

  // One clock cycle: apply inputs after the edge, check at the falling edge, then advance the model.
  task automatic cycle(input bit en, input bit dreq, input logic [18:0] daddr,
                       input bit creq, input bit cwe, input logic [18:0] caddr,
                       input logic [11:0] cwd, input bit clr);
    bit issue, stall_c;
    @(posedge clk); #1;
    module_en = en; disp_req = dreq; disp_addr = daddr;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd; err_clr = clr;
    @(negedge clk);
    cyc++;
    issue   = en && m_busy && !m_issued && !dreq;
    stall_c = en && m_busy && !m_issued && dreq;
    if (m_busy && m_issued && cyc == m_ack_cyc && !m_we) m_rdata = m_pend_rdata;
    check("cpu_busy", cpu_busy, m_busy);
    check("cpu_ack", cpu_ack, m_busy && m_issued && cyc == m_ack_cyc);
    check("cpu_rdata", cpu_rdata, m_rdata);
    check("cpu_timeout", cpu_timeout, m_to);
    check("disp_valid", disp_valid, m_prev_disp);
    if (m_prev_disp) check("disp_data", disp_data, m_prev_exp);
    check("mem_we", mem_we, issue && m_we);
    check("mem_addr", mem_addr, issue ? m_addr : daddr);
    if (issue) check("mem_wdata", mem_wdata, m_wdata);
    m_prev_disp = dreq && en;
    m_prev_exp  = sh_rd(daddr);
    if (stall_c) m_stalls++;
    if (stall_c && m_stalls >= TO) m_to = 1;
    else if (clr) m_to = 0;
    if (!en) begin
      m_busy = 0; m_stalls = 0;
    end else if (m_busy) begin
      if (issue) begin
        m_issued  = 1;
        m_ack_cyc = cyc + (m_we ? 1 : 2);
        if (m_we) begin
          shadow[m_addr] = m_wdata; shadow_wr[m_addr] = 1'b1;
        end else begin
          m_pend_rdata = sh_rd(m_addr);
        end
      end else if (m_issued && cyc == m_ack_cyc) begin
        m_busy = 0;
      end
    end else if (creq) begin
      m_busy = 1; m_issued = 0; m_we = cwe; m_addr = caddr; m_wdata = cwd; m_stalls = 0;
    end
  endtask

  task automatic idle(input logic [18:0] daddr);
    cycle(1, 0, daddr, 0, 0, 19'd0, 12'd0, 0);
  endtask

  // Asynchronous reset mid-cycle; outputs must drop without waiting for a clock edge.
  task automatic do_reset(input bit chk_busy);
    @(posedge clk); #1;
    if (chk_busy) check("pre_rst_busy", cpu_busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", cpu_busy, 1'b0);
    check("rst_ack", cpu_ack, 1'b0);
    check("rst_disp_valid", disp_valid, 1'b0);
    check("rst_timeout", cpu_timeout, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rdata", cpu_rdata, 12'd0);
    module_en = 1'b1; disp_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int nvalid;
    int idx;
    logic [18:0] a;
    rst_n = 1'b0; module_en = 1'b1; disp_req = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_busy", cpu_busy, 1'b0);
    check("init_ack", cpu_ack, 1'b0);
    check("init_disp_valid", disp_valid, 1'b0);
    check("init_timeout", cpu_timeout, 1'b0);
    check("init_mem_we", mem_we, 1'b0);
    check("init_rdata", cpu_rdata, 12'd0);
    rst_n = 1'b1;

    // CPU write then read-back with an idle display
    cycle(1, 0, 19'h100, 1, 1, 19'h00010, 12'hABC, 0);
    idle(19'h101);
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_addr", mem_addr, 19'h00010);
    check("wr_mem_wdata", mem_wdata, 12'hABC);
    idle(19'h102);
    check("wr_ack", cpu_ack, 1'b1);
    idle(19'h103);
    check("wr_ack_pulse", cpu_ack, 1'b0);
    cycle(1, 0, 19'h104, 1, 0, 19'h00010, 12'h000, 0);
    idle(19'h105);
    idle(19'h106);
    idle(19'h107);
    check("rd_ack", cpu_ack, 1'b1);
    check("rd_data", cpu_rdata, 12'hABC);
    idle(19'h108);

    // CPU read starved by 800 display cycles
    cycle(1, 1, 19'd0, 1, 0, 19'h00020, 12'h000, 0);
    for (int i = 1; i <= 800; i++) cycle(1, 1, 19'(i), 0, 0, 19'd0, 12'd0, 0);
    check("starve_busy", cpu_busy, 1'b1);
    check("starve_no_ack", cpu_ack, 1'b0);
    idle(19'h200);
    check("starve_issue_addr", mem_addr, 19'h00020);
    check("starve_issue_we", mem_we, 1'b0);
    cycle(1, 1, 19'h201, 0, 0, 19'd0, 12'd0, 0);
    idle(19'h202);
    check("starve_ack", cpu_ack, 1'b1);
    check("starve_rdata", cpu_rdata, init_val(19'h00020));
    cycle(1, 0, 19'h203, 0, 0, 19'd0, 12'd0, 1);
    idle(19'h204);

    // Timeout after eight stall cycles, sticky until cleared
    cycle(1, 1, 19'h300, 1, 1, 19'h00040, 12'h5A5, 0);
    for (int k = 1; k <= 20; k++) begin
      cycle(1, 1, 19'(32'h300 + k), 0, 0, 19'd0, 12'd0, 0);
      if (k == 8) check("to_before", cpu_timeout, 1'b0);
      if (k == 9) check("to_after", cpu_timeout, 1'b1);
    end
    idle(19'h320);
    idle(19'h321);
    check("to_wr_ack", cpu_ack, 1'b1);
    idle(19'h322);
    check("to_sticky", cpu_timeout, 1'b1);
    cycle(1, 0, 19'h323, 0, 0, 19'd0, 12'd0, 1);
    idle(19'h324);
    check("to_cleared", cpu_timeout, 1'b0);

    // Continuous display stream 0..639 with one gap that lets a CPU read through
    nvalid = 0;
    idx = 0;
    for (int s = 0; s <= 640; s++) begin
      if (s == 300) begin
        cycle(1, 0, 19'h7FFFF, 0, 0, 19'd0, 12'd0, 0);
      end else begin
        cycle(1, 1, 19'(idx), (s == 0), 0, 19'h00040, 12'd0, 0);
        idx++;
      end
      if (s > 0 && disp_valid === 1'b1) nvalid++;
      if (s == 302) check("stream_rd_ack", cpu_ack, 1'b1);
    end
    cycle(1, 0, 19'd0, 0, 0, 19'd0, 12'd0, 1);
    if (disp_valid === 1'b1) nvalid++;
    check("stream_count", nvalid, 640);
    idle(19'h400);

    // module_en dropped while a write is pending
    cycle(1, 1, 19'h500, 1, 1, 19'h00050, 12'h321, 0);
    cycle(0, 0, 19'h501, 0, 0, 19'd0, 12'd0, 0);
    check("dis_no_we", mem_we, 1'b0);
    idle(19'h502);
    check("dis_busy", cpu_busy, 1'b0);
    check("dis_no_ack", cpu_ack, 1'b0);
    cycle(1, 0, 19'h503, 1, 1, 19'h00051, 12'h654, 0);
    idle(19'h504);
    check("dis_reaccept", cpu_busy, 1'b1);
    idle(19'h505);
    idle(19'h506);
    check("dis_mem_kept", vram_rd(19'h00050), init_val(19'h00050));

    // Reset while a write is stalled in PEND
    cycle(1, 1, 19'h600, 1, 1, 19'h00060, 12'hF0F, 0);
    cycle(1, 1, 19'h601, 0, 0, 19'd0, 12'd0, 0);
    do_reset(1);
    idle(19'h602);
    idle(19'h603);
    check("rst_pend_no_write", vram_rd(19'h00060), init_val(19'h00060));

    // Reset while in RDWAIT
    cycle(1, 0, 19'h700, 1, 0, 19'h00010, 12'd0, 0);
    idle(19'h701);
    do_reset(1);
    for (int i = 0; i < 4; i++) idle(19'(32'h702 + i));

    // Randomized traffic over a small address window
    for (int i = 0; i < 3000; i++) begin
      a = 19'($urandom_range(0, 63));
      cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) < 6), a,
            ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
            19'($urandom_range(0, 63)), 12'($urandom), ($urandom_range(0, 31) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
